// File: rtl/elevador_pkg.sv
// rtl/elevador_pkg.sv - shared constants and state type for the elevador controller
package elevador_pkg;

    localparam int NUM_FLOORS = 5;
    localparam int FLOOR_W    = 3;

    localparam int DEFAULT_FLOOR_CYCLES = 4;
    localparam int DEFAULT_MAX_PEOPLE   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/elevador_req_encoder.sv
// rtl/elevador_req_encoder.sv - highest-set-bit encoder for the floor request vector
module elevador_req_encoder
    import elevador_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] i_req,
    output logic                  o_valid,
    output logic [FLOOR_W-1:0]    o_floor
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        o_valid = |i_req;
        o_floor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i_req[i]) begin
                o_floor = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/elevador.sv
// rtl/elevador.sv - five-floor elevator controller with travel timer and passenger count
module elevador
    import elevador_pkg::*;
#(
    parameter int FLOOR_CYCLES = DEFAULT_FLOOR_CYCLES,
    parameter int MAX_PEOPLE   = DEFAULT_MAX_PEOPLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  person_enter,
    input  logic                  person_exit,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  busy,
    output logic [FLOOR_W-1:0]    andar_atual,
    output logic [FLOOR_W-1:0]    andar_requisitado,
    output logic [3:0]            num_people
);

    localparam int TIMER_W = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FLOOR_CYCLES - 1);
    localparam logic [3:0]         PEOPLE_MAX = 4'(MAX_PEOPLE);

    state_t               r_state;
    logic [FLOOR_W-1:0]   r_floor;
    logic [FLOOR_W-1:0]   r_target;
    logic [TIMER_W-1:0]   r_timer;
    logic [3:0]           r_people;

    logic                 w_req_valid;
    logic [FLOOR_W-1:0]   w_req_floor;
    logic [FLOOR_W-1:0]   w_next_floor;
    logic                 w_floor_step;

    elevador_req_encoder u_req_encoder (
        .i_req   (req),
        .o_valid (w_req_valid),
        .o_floor (w_req_floor)
    );

    assign w_floor_step = (r_timer == TIMER_LAST);
    assign w_next_floor = (r_state == ST_UP) ? (r_floor + FLOOR_W'(1))
                                             : (r_floor - FLOOR_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_floor  <= '0;
            r_target <= '0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        r_target <= w_req_floor;
                        r_timer  <= '0;
                        if (w_req_floor > r_floor) begin
                            r_state <= ST_UP;
                        end else if (w_req_floor < r_floor) begin
                            r_state <= ST_DOWN;
                        end
                    end
                end
                ST_UP, ST_DOWN: begin
                    // Requests are ignored here; the latched target is fixed until arrival.
                    if (w_floor_step) begin
                        r_timer <= '0;
                        r_floor <= w_next_floor;
                        if (w_next_floor == r_target) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Boarding is only counted with the car stopped; the edge that starts motion still counts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_people <= '0;
        end else if (r_state == ST_IDLE) begin
            case ({person_enter, person_exit})
                2'b10: if (r_people < PEOPLE_MAX) r_people <= r_people + 4'd1;
                2'b01: if (r_people != 4'd0)      r_people <= r_people - 4'd1;
                default: ;
            endcase
        end
    end

    assign motor_up          = (r_state == ST_UP);
    assign motor_down        = (r_state == ST_DOWN);
    assign busy              = (r_state != ST_IDLE);
    assign andar_atual       = r_floor;
    assign andar_requisitado = r_target;
    assign num_people        = r_people;

endmodule

// File: tb/tb_elevador.sv
// tb/tb_elevador.sv - directed and randomized check of elevador against a trip-level model
module tb_elevador;

    localparam int FC = 4;
    localparam int MP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] req;
    logic       person_enter;
    logic       person_exit;
    logic       motor_up;
    logic       motor_down;
    logic       busy;
    logic [2:0] andar_atual;
    logic [2:0] andar_requisitado;
    logic [3:0] num_people;

    int n_cmp = 0;
    int n_bad = 0;

    // Trip-level model: a trip is a target plus the cycles left until arrival.
    int m_floor, m_target, m_people, m_remaining;
    bit m_busy, m_up;

    elevador #(.FLOOR_CYCLES(FC), .MAX_PEOPLE(MP)) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .person_enter      (person_enter),
        .person_exit       (person_exit),
        .motor_up          (motor_up),
        .motor_down        (motor_down),
        .busy              (busy),
        .andar_atual       (andar_atual),
        .andar_requisitado (andar_requisitado),
        .num_people        (num_people)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int highest_req(input logic [4:0] r);
        for (int i = 4; i >= 0; i--) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_edge(input bit rst_n, input logic [4:0] r, input bit en, input bit ex);
        int t, legs;
        if (!rst_n) begin
            m_floor = 0; m_target = 0; m_people = 0; m_remaining = 0; m_busy = 0; m_up = 0;
            return;
        end
        if (!m_busy) begin
            if (en && !ex && m_people < MP) m_people++;
            if (ex && !en && m_people > 0)  m_people--;
            t = highest_req(r);
            if (t >= 0) begin
                m_target = t;
                if (t != m_floor) begin
                    m_busy      = 1;
                    m_up        = (t > m_floor);
                    m_remaining = FC * (m_up ? t - m_floor : m_floor - t);
                end
            end
        end else begin
            m_remaining--;
            legs    = (m_remaining + FC - 1) / FC;
            m_floor = m_up ? m_target - legs : m_target + legs;
            if (m_remaining == 0) m_busy = 0;
        end
    endtask

    task automatic cyc(input logic [4:0] r, input bit en, input bit ex, input bit rst_n);
        reset = rst_n; req = r; person_enter = en; person_exit = ex;
        @(posedge clk);
        model_edge(rst_n, r, en, ex);
        #1;
        check_val("andar_atual", andar_atual, m_floor);
        check_val("andar_requisitado", andar_requisitado, m_target);
        check_val("busy", busy, m_busy);
        check_val("motor_up", motor_up, m_busy && m_up);
        check_val("motor_down", motor_down, m_busy && !m_up);
        check_val("num_people", num_people, m_people);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(5'b0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b0; req = '0; person_enter = 0; person_exit = 0;
        m_floor = 0; m_target = 0; m_people = 0; m_remaining = 0; m_busy = 0; m_up = 0;

        cyc(5'b0, 0, 0, 0);
        cyc(5'b0, 0, 0, 0);
        check_val("rst_floor", andar_atual, 0);
        check_val("rst_people", num_people, 0);

        cyc(5'b10000, 0, 0, 1);
        check_val("up_target", andar_requisitado, 4);
        check_val("up_motor", motor_up, 1);
        idle_cycles(4);
        check_val("up_floor1", andar_atual, 1);
        idle_cycles(12);
        check_val("up_floor4", andar_atual, 4);
        check_val("up_done_busy", busy, 0);

        cyc(5'b0, 1, 0, 1);
        cyc(5'b0, 1, 0, 1);
        check_val("enter2", num_people, 2);
        cyc(5'b01000, 0, 0, 1);
        check_val("down_motor", motor_down, 1);
        idle_cycles(4);
        check_val("down_floor3", andar_atual, 3);

        cyc(5'b00001, 0, 0, 1);
        idle_cycles(12);
        check_val("down_floor0", andar_atual, 0);
        for (int i = 0; i < 3; i++) cyc(5'b0, 0, 1, 1);
        check_val("exit_sat0", num_people, 0);

        for (int i = 0; i < 12; i++) cyc(5'b0, 1, 0, 1);
        check_val("enter_sat", num_people, 8);
        for (int i = 0; i < 3; i++) cyc(5'b0, 0, 1, 1);
        cyc(5'b00100, 0, 0, 1);
        cyc(5'b0, 1, 0, 1);
        check_val("blocked_enter", num_people, 5);
        idle_cycles(7);

        cyc(5'b10100, 0, 0, 1);
        check_val("prio_target", andar_requisitado, 4);
        idle_cycles(8);
        cyc(5'b10000, 0, 0, 1);
        check_val("same_floor_busy", busy, 0);

        cyc(5'b0, 0, 0, 0);
        cyc(5'b00100, 0, 0, 1);
        idle_cycles(5);
        cyc(5'b0, 0, 0, 0);
        check_val("midrst_floor", andar_atual, 0);
        check_val("midrst_busy", busy, 0);

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0;
            cyc(r, 1'($urandom), 1'($urandom), $urandom_range(0, 249) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elevador.md
Name: elevador

Overview:
- Five-floor elevator controller (floors 0–4); floor 0 is the ground floor.
- Samples a floor-request vector while idle and drives up/down motor outputs.
- Moves one floor every FLOOR_CYCLES clocks and stops at the target floor.
- Tracks the number of passengers on board; sits between the call-button panel and the motor/display logic.

Parameters:
- FLOOR_CYCLES, default 4: clock cycles needed to travel one floor (legal values ≥1).
- MAX_PEOPLE, default 8: passenger capacity; the count saturates here (≤15).

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req  in  5  floor requests; bit i = call for floor i; level-sampled.
- person_enter  in  1  level; one passenger boards per clock while high.
- person_exit  in  1  level; one passenger leaves per clock while high.
- motor_up  out  1  high while in state UP.
- motor_down  out  1  high while in state DOWN.
- busy  out  1  high while moving (state ≠ IDLE).
- andar_atual  out  3  current floor, 0–4.
- andar_requisitado  out  3  latched target floor, 0–4.
- num_people  out  4  passengers on board, 0..MAX_PEOPLE.

Behaviour:
- Reset (reset=0 at a clock edge, including mid-travel):
  - state=IDLE, andar_atual=0, andar_requisitado=0, num_people=0, timer=0.
  - motor_up=0, motor_down=0, busy=0.
- States: IDLE, UP, DOWN. Motor and busy outputs decode from the registered state and have no combinational path from the inputs.
- IDLE with req≠0:
  - Target = index of the highest set bit of req (priority encoder).
  - andar_requisitado ← target on that edge.
  - Target > andar_atual → UP; target < andar_atual → DOWN; equal → stay IDLE.
  - timer ← 0.
- IDLE with req=0: no change; andar_requisitado holds its value.
- UP/DOWN:
  - req is ignored; the target cannot change mid-travel.
  - timer increments each clock.
  - When timer = FLOOR_CYCLES−1: andar_atual ±1, timer ← 0. If the new floor equals the target, go to IDLE on the same edge.
  - Travel from floor a to floor b takes exactly FLOOR_CYCLES·|a−b| cycles after the latch edge.
- A request still asserted on arrival (equal to the current floor) causes no motion. A new request is honoured on the first IDLE cycle.
- Floor range: andar_atual never leaves 0–4. This follows from the targets being limited to 0–4.
- Passenger count (evaluated only when busy=0; ignored while moving):
  - enter=1, exit=0: +1, saturating at MAX_PEOPLE.
  - enter=0, exit=1: −1, saturating at 0.
  - Both high or both low: no change.
- Counting and request latching may occur on the same IDLE edge. The counter updates normally on the edge where motion starts; from the next cycle busy=1 blocks it.

Decomposition:
- Package elevador_pkg:
  - NUM_FLOORS=5 and FLOOR_W=3.
  - State enum {IDLE, UP, DOWN}.
  - Default FLOOR_CYCLES and MAX_PEOPLE constants.
- Sub-module: elevador_req_encoder, a combinational 5-bit highest-set-bit encoder producing a valid flag and a 3-bit floor index.
- The FSM, travel timer and passenger counter stay in elevador.

Test Plan:
- Reset with reset=0 for 2 cycles → all outputs 0; andar_atual=0; num_people=0.
- From floor 0, req=5'b10000 → andar_requisitado=4 and motor_up=1 on the next cycle. andar_atual steps 1, 2, 3, 4 every 4 cycles. At floor 4: busy=0, motor_up=0.
- At floor 4, idle, person_enter high for exactly 2 clocks → num_people=2. Then req=5'b01000 → motor_down=1, floor 3 reached after 4 cycles.
- At floor 3, req=5'b00001 → descends to 0 in 12 cycles. With person_exit held high 3 cycles from num_people=2 → num_people=0 (saturates, no wrap).
- Capacity and blocking:
  - person_enter held 12 cycles → num_people=8.
  - person_enter pulsed during UP → no change.
  - req=5'b10100 → target 4.
  - req equal to the current floor → busy stays 0.
- Assert reset mid-travel between floors 1 and 2 → next cycle andar_atual=0, busy=0, motors off, num_people=0.
